// File: rtl/ram_pkg.sv
// Shared types and helpers for the inferred work-RAM primitives.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ssbus_if.sv
// Save-state bus: the host selects an instance by index and moves one word per cycle.
interface ssbus_if;
  logic [7:0]  select;
  logic [31:0] addr;
  logic [63:0] data;
  logic        read;
  logic        write;
  logic        write_ack;
  logic        read_response;
  logic [63:0] read_data;
  logic [7:0]  setup_idx;
  logic [31:0] setup_count;
  logic [7:0]  setup_type;

  modport slave (
    input  select, addr, data, read, write,
    output write_ack, read_response, read_data, setup_idx, setup_count, setup_type
  );

  modport master (
    output select, addr, data, read, write,
    input  write_ack, read_response, read_data, setup_idx, setup_count, setup_type
  );
endinterface

// File: rtl/ram_clear_seq.sv
// Boot-time clear sequencer: walks every address once after reset, then parks in READY.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int WIDTHAD = 10
) (
  input  logic               clock_i,
  input  logic               reset_i,
  output logic [WIDTHAD-1:0] clr_addr_o,
  output logic               clr_we_o,
  output logic               busy_o
);

  ram_state_e         state_q;
  logic [WIDTHAD-1:0] addr_q;
  logic               busy_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == '1) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_READY;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_addr_o = addr_q;
  assign clr_we_o   = busy_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/ss_dualport_ram.sv
// Dual-port byte-writable RAM with boot clear and save-state access pre-empting port B.
// Port A (or the clear sequencer) wins any byte lane it shares with port B / ss.
module ss_dualport_ram
  import ram_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               WIDTHAD     = 10,
  parameter string            NAME        = "NONE",
  parameter int               SS_IDX      = 0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        busy,
  input  logic                        wren_a,
  input  logic [bytes_of(WIDTH)-1:0]  be_a,
  input  logic [WIDTHAD-1:0]          address_a,
  input  logic [WIDTH-1:0]            data_a,
  output logic [WIDTH-1:0]            q_a,
  input  logic                        wren_b,
  input  logic [bytes_of(WIDTH)-1:0]  be_b,
  input  logic [WIDTHAD-1:0]          address_b,
  input  logic [WIDTH-1:0]            data_b,
  output logic [WIDTH-1:0]            q_b,
  output logic                        stall_b,
  ssbus_if.slave                      ssbus
);

  localparam int NB    = bytes_of(WIDTH);
  localparam int DEPTH = 2 ** WIDTHAD;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTHAD-1:0] clr_addr;
  logic               clr_we;
  logic               ss_access;
  logic [WIDTHAD-1:0] ss_addr;
  logic               unused_ok;

  logic [NB-1:0]      en_a, en_b;
  logic [WIDTHAD-1:0] ad_a, ad_b;
  logic [WIDTH-1:0]   dat_a, dat_b;
  logic [WIDTH-1:0]   q_a_d, q_a_q, q_b_d, q_b_q;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                             input logic [WIDTH-1:0] new_w,
                                             input logic [NB-1:0]    en);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  ram_clear_seq #(.WIDTHAD(WIDTHAD)) u_clear (
    .clock_i    (clock),
    .reset_i    (reset),
    .clr_addr_o (clr_addr),
    .clr_we_o   (clr_we),
    .busy_o     (busy)
  );

  assign ss_access = (ssbus.select == 8'(SS_IDX)) && (ssbus.read || ssbus.write);
  assign ss_addr   = ssbus.addr[WIDTHAD-1:0];
  assign unused_ok = ^{ssbus.data, ssbus.addr};

  always_comb begin
    en_a  = clr_we ? '1 : (wren_a ? be_a : '0);
    ad_a  = clr_we ? clr_addr : address_a;
    dat_a = clr_we ? CLEAR_VALUE : data_a;
  end

  always_comb begin
    en_b  = '0;
    ad_b  = address_b;
    dat_b = data_b;
    if (!busy) begin
      if (ss_access) begin
        en_b  = ssbus.write ? '1 : '0;
        ad_b  = ss_addr;
        dat_b = ssbus.data[WIDTH-1:0];
      end else begin
        en_b = wren_b ? be_b : '0;
      end
    end
  end

  // B lanes first so that overlapping A lanes overwrite them.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (en_b[i]) mem[ad_b][8*i +: 8] <= dat_b[8*i +: 8];
    end
    for (int i = 0; i < NB; i++) begin
      if (en_a[i]) mem[ad_a][8*i +: 8] <= dat_a[8*i +: 8];
    end
  end

  always_comb begin
    q_a_d = '0;
    q_b_d = '0;
    if (!busy) begin
      q_a_d = merge(mem[address_a], data_a, en_a);
      q_b_d = ss_access ? q_b_q : merge(mem[address_b], data_b, en_b);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_a_q <= '0;
      q_b_q <= '0;
    end else begin
      q_a_q <= q_a_d;
      q_b_q <= q_b_d;
    end
  end

  assign q_a     = q_a_q;
  assign q_b     = q_b_q;
  assign stall_b = busy | ss_access;

  assign ssbus.write_ack     = !busy && ss_access && ssbus.write;
  assign ssbus.read_response = !busy && ss_access && ssbus.read;
  assign ssbus.read_data     = 64'(mem[ss_addr]);
  assign ssbus.setup_idx     = 8'(SS_IDX);
  assign ssbus.setup_count   = 32'(DEPTH);
  assign ssbus.setup_type    = 8'd0;

endmodule

// File: tb/tb_ss_dualport_ram.sv
// Randomized bench for ss_dualport_ram against a word-array reference model.
module tb_ss_dualport_ram;

  localparam int          W     = 16;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          SSI   = 2;
  localparam logic [15:0] CV    = 16'hA5A5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          busy, stall_b;
  logic          wren_a, wren_b;
  logic [1:0]    be_a, be_b;
  logic [AW-1:0] address_a, address_b;
  logic [W-1:0]  data_a, data_b, q_a, q_b;

  ssbus_if ss ();

  ss_dualport_ram #(
    .WIDTH(W), .WIDTHAD(AW), .NAME("TBRAM"), .SS_IDX(SSI), .CLEAR_VALUE(CV)
  ) dut (
    .clock(clock), .reset(reset), .busy(busy),
    .wren_a(wren_a), .be_a(be_a), .address_a(address_a), .data_a(data_a), .q_a(q_a),
    .wren_b(wren_b), .be_b(be_b), .address_b(address_b), .data_b(data_b), .q_b(q_b),
    .stall_b(stall_b), .ssbus(ss)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] qb_model;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lanes(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic idle();
    wren_a = 0; be_a = 0; address_a = 0; data_a = 0;
    wren_b = 0; be_b = 0; address_b = 0; data_b = 0;
    ss.select = 8'd0; ss.addr = 32'd0; ss.data = 64'd0; ss.read = 0; ss.write = 0;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (1) begin
      @(posedge clock); #1;
      cnt++;
      if (!busy || cnt >= 100) break;
    end
  endtask

  // One READY cycle with inputs already applied; model computed from old contents.
  task automatic step(input string tag);
    logic        acc;
    logic [15:0] ma, mb, ea, eb;
    #1;
    acc = (ss.select == 8'(SSI)) && (ss.read || ss.write);
    check({tag, "_stall"}, 64'(stall_b), 64'(acc));
    check({tag, "_ack"},   64'(ss.write_ack), 64'(acc && ss.write));
    check({tag, "_resp"},  64'(ss.read_response), 64'(acc && ss.read));
    if (acc && ss.read) check({tag, "_rdata"}, ss.read_data, {48'd0, ref_mem[ss.addr[3:0]]});
    ma = wren_a ? lanes(be_a) : 16'd0;
    mb = wren_b ? lanes(be_b) : 16'd0;
    ea = (ref_mem[address_a] & ~ma) | (data_a & ma);
    eb = acc ? qb_model : ((ref_mem[address_b] & ~mb) | (data_b & mb));
    if (acc && ss.write) ref_mem[ss.addr[3:0]] = ss.data[15:0];
    else if (!acc) ref_mem[address_b] = (ref_mem[address_b] & ~mb) | (data_b & mb);
    ref_mem[address_a] = (ref_mem[address_a] & ~ma) | (data_a & ma);
    @(posedge clock); #1;
    check({tag, "_qa"}, 64'(q_a), 64'(ea));
    check({tag, "_qb"}, 64'(q_b), 64'(eb));
    qb_model = eb;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      idle();
      address_a = 4'(i);
      address_b = 4'(DEPTH - 1 - i);
      step(tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    idle();
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_qa", 64'(q_a), 64'd0);
    check("rst_qb", 64'(q_b), 64'd0);
    check("rst_stall", 64'(stall_b), 64'd1);
    check("setup_count", 64'(ss.setup_count), 64'(DEPTH));
    check("setup_idx", 64'(ss.setup_idx), 64'(SSI));

    @(negedge clock);
    reset = 0;
    wait_clear(cnt);
    check("clear_len", 64'(cnt), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CV;
    qb_model = 16'd0;
    read_all("clr_rd");

    // Byte-masked write on A, write-first readback.
    @(negedge clock);
    idle(); wren_a = 1; be_a = 2'b01; address_a = 4'd3; data_a = 16'h1234;
    step("a_wr");
    check("a_wr_q", 64'(q_a), 64'h A534);
    @(negedge clock);
    idle(); address_a = 4'd3;
    step("a_rd");
    check("a_rd_q", 64'(q_a), 64'h A534);

    // Same-address collision: A lane 0 wins, B keeps lane 1.
    @(negedge clock);
    idle();
    wren_a = 1; be_a = 2'b01; address_a = 4'd5; data_a = 16'h1111;
    wren_b = 1; be_b = 2'b11; address_b = 4'd5; data_b = 16'h2222;
    step("coll");
    @(negedge clock);
    idle(); address_a = 4'd5; address_b = 4'd5;
    step("coll_rd");
    check("coll_rd_qa", 64'(q_a), 64'h2211);
    check("coll_rd_qb", 64'(q_b), 64'h2211);

    // ss write pre-empts a B write to the same word.
    @(negedge clock);
    idle();
    wren_b = 1; be_b = 2'b11; address_b = 4'd7; data_b = 16'h0001;
    ss.select = 8'(SSI); ss.write = 1; ss.addr = 32'd7; ss.data = 64'h0000_0000_0000_BEEF;
    #1;
    check("ss_wr_stall", 64'(stall_b), 64'd1);
    check("ss_wr_ack", 64'(ss.write_ack), 64'd1);
    step("ss_wr");
    check("ss_wr_qb_hold", 64'(q_b), 64'h2211);
    @(negedge clock);
    idle(); address_a = 4'd7;
    ss.select = 8'(SSI); ss.read = 1; ss.addr = 32'd7;
    #1;
    check("ss_rd_data", ss.read_data, 64'h0000_0000_0000_BEEF);
    step("ss_rd");
    check("ss_rd_qa", 64'(q_a), 64'hBEEF);

    for (int n = 0; n < 400; n++) begin
      int op;
      @(negedge clock);
      wren_a    = 1'($urandom_range(0, 1));
      be_a      = 2'($urandom_range(0, 3));
      address_a = 4'($urandom_range(0, 7));
      data_a    = 16'($urandom);
      wren_b    = 1'($urandom_range(0, 1));
      be_b      = 2'($urandom_range(0, 3));
      address_b = 4'($urandom_range(0, 7));
      data_b    = 16'($urandom);
      ss.select = ($urandom_range(0, 2) == 0) ? 8'd5 : 8'(SSI);
      op        = int'($urandom_range(0, 2));
      ss.read   = (op == 1);
      ss.write  = (op == 2);
      ss.addr   = 32'($urandom_range(0, 7));
      ss.data   = {32'($urandom), 32'($urandom)};
      step("rnd");
    end

    // Reset again partway through a clear; ports and ss must be ignored while busy.
    @(negedge clock);
    idle();
    reset = 1;
    @(negedge clock);
    reset = 0;
    repeat (7) @(posedge clock);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    wren_a = 1; be_a = 2'b11; address_a = 4'd0; data_a = 16'h0000;
    wren_b = 1; be_b = 2'b11; address_b = 4'd1; data_b = 16'h0000;
    ss.select = 8'(SSI); ss.read = 1; ss.addr = 32'd2;
    cnt = 0;
    while (1) begin
      @(posedge clock); #1;
      cnt++;
      if (!busy || cnt >= 100) break;
      check("busy_noresp", 64'(ss.read_response), 64'd0);
      check("busy_stall", 64'(stall_b), 64'd1);
      if (cnt == 12) begin
        wren_a = 0;
        wren_b = 0;
      end
    end
    check("reclear_len", 64'(cnt), 64'(DEPTH));
    check("ready_resp", 64'(ss.read_response), 64'd1);
    check("ready_rdata", ss.read_data, 64'(CV));
    check("ready_qa", 64'(q_a), 64'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = CV;
    qb_model = 16'd0;
    read_all("reclr_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
